// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 4-bit CPU slice. Holds the
//               sequencer state enum and the opcode constants that the ALU
//               decodes from the instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Sequencer states: one instruction takes FETCH -> LATCH -> EXEC.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_EXEC  = 2'd3
  } state_e;

  // Opcodes carried in IR[7:4]; the immediate lives in IR[3:0].
  localparam logic [3:0] OP_ADD_A  = 4'h0;  // A   <= A + imm
  localparam logic [3:0] OP_MOV_AB = 4'h1;  // A   <= B
  localparam logic [3:0] OP_IN_A   = 4'h2;  // A   <= in
  localparam logic [3:0] OP_MOV_A  = 4'h3;  // A   <= imm
  localparam logic [3:0] OP_MOV_BA = 4'h4;  // B   <= A
  localparam logic [3:0] OP_ADD_B  = 4'h5;  // B   <= B + imm
  localparam logic [3:0] OP_IN_B   = 4'h6;  // B   <= in
  localparam logic [3:0] OP_MOV_B  = 4'h7;  // B   <= imm
  localparam logic [3:0] OP_OUT_B  = 4'h9;  // OUT <= B
  localparam logic [3:0] OP_OUT_I  = 4'hB;  // OUT <= imm
  localparam logic [3:0] OP_JNC    = 4'hE;  // pc  <= imm when carry clear
  localparam logic [3:0] OP_JMP    = 4'hF;  // pc  <= imm

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for the 4-bit asynchronous input port.
//               Both stages clear to zero on reset.
// Ports       : clk  - clock
//               nrst - synchronous active-low reset
//               d    - asynchronous input
//               q    - second-stage (synchronized) value
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      meta_q <= 4'd0;
      sync_q <= 4'd0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Instruction sequencer for a 4-bit CPU. Fetches an 8-bit word
//               from ROM, latches it into IR, presents it to an external ALU
//               and commits the ALU's decode results (register writes, carry,
//               jump) at the end of EXEC.
// Ports       : clk, nrst          - clock, synchronous active-low reset
//               run, step          - free-run level / single-step pulse
//               rom_en, rom_addr   - ROM read strobe and address (= pc)
//               rom_data           - ROM word, valid the cycle after rom_en
//               in_port            - asynchronous input (synchronized inside)
//               alu_cmd, alu_imd   - IR fields to the ALU
//               alu_a, alu_b       - registers A and B
//               alu_in, alu_ci     - synchronized input, carry flag
//               alu_wa/wb/wo       - ALU write enables for A, B, OUT
//               alu_jump, alu_co   - ALU jump request and carry out
//               alu_data           - ALU result
//               out_port, pc       - OUT register, program counter
//               busy, instr_done   - not-idle flag, per-instruction pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       run,
  input  logic       step,
  output logic       rom_en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] alu_cmd,
  output logic [3:0] alu_imd,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_in,
  output logic       alu_ci,
  input  logic       alu_wa,
  input  logic       alu_wb,
  input  logic       alu_wo,
  input  logic       alu_jump,
  input  logic       alu_co,
  input  logic [3:0] alu_data,
  output logic [3:0] out_port,
  output logic [3:0] pc,
  output logic       busy,
  output logic       instr_done
);

  state_e     state_q, state_d;
  logic [3:0] pc_q,    pc_d;
  logic [3:0] a_q,     a_d;
  logic [3:0] b_q,     b_d;
  logic [3:0] out_q,   out_d;
  logic [7:0] ir_q,    ir_d;
  logic       c_q,     c_d;
  logic       done_q,  done_d;

  sync2 u_sync2 (
    .clk  (clk),
    .nrst (nrst),
    .d    (in_port),
    .q    (alu_in)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      pc_q    <= 4'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      out_q   <= 4'd0;
      ir_q    <= 8'd0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    ir_d    = ir_q;
    c_d     = c_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // run and step lead to the same place; step is only honoured here.
        if (run || step) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ir_d    = rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (alu_wa) a_d   = alu_data;
        if (alu_wb) b_d   = alu_data;
        if (alu_wo) out_d = alu_data;
        c_d    = alu_co;
        // 4-bit add wraps 15 -> 0 naturally.
        pc_d   = alu_jump ? alu_data : pc_q + 4'd1;
        done_d = 1'b1;
        // run is re-sampled only here, so a mid-instruction drop still
        // lets the current instruction finish.
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_en     = (state_q == ST_FETCH);
  assign rom_addr   = pc_q;
  assign busy       = (state_q != ST_IDLE);
  assign instr_done = done_q;
  // IR is stable outside LATCH, so the ALU sees the held IR fields in every
  // state and the decoded fields in EXEC.
  assign alu_cmd    = ir_q[7:4];
  assign alu_imd    = ir_q[3:0];
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ci     = c_q;
  assign out_port   = out_q;
  assign pc         = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer. Provides a ROM and a
//               behavioural ALU around the sequencer, a table of single-step
//               vectors, hand-written multi-cycle sequences and a randomized
//               free-running program checked against an instruction-level
//               model of the architectural state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [3:0] in_port = 4'h0;
  logic [3:0] alu_cmd, alu_imd, alu_a, alu_b, alu_in;
  logic       alu_ci;
  logic       alu_wa, alu_wb, alu_wo, alu_jump, alu_co;
  logic [3:0] alu_data;
  logic [3:0] out_port, pc;
  logic       busy, instr_done;

  logic [7:0] rom [16];

  int n_checks = 0;
  int n_fail   = 0;

  cpu_sequencer dut (
    .clk        (clk),
    .nrst       (nrst),
    .run        (run),
    .step       (step),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .in_port    (in_port),
    .alu_cmd    (alu_cmd),
    .alu_imd    (alu_imd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_in     (alu_in),
    .alu_ci     (alu_ci),
    .alu_wa     (alu_wa),
    .alu_wb     (alu_wb),
    .alu_wo     (alu_wo),
    .alu_jump   (alu_jump),
    .alu_co     (alu_co),
    .alu_data   (alu_data),
    .out_port   (out_port),
    .pc         (pc),
    .busy       (busy),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  // Behavioural ALU living beside the sequencer.
  logic [4:0] sum_a, sum_b;
  assign sum_a = {1'b0, alu_a} + {1'b0, alu_imd};
  assign sum_b = {1'b0, alu_b} + {1'b0, alu_imd};

  always_comb begin
    alu_wa   = 1'b0;
    alu_wb   = 1'b0;
    alu_wo   = 1'b0;
    alu_jump = 1'b0;
    alu_co   = 1'b0;
    alu_data = alu_imd;
    case (alu_cmd)
      OP_ADD_A:  begin alu_data = sum_a[3:0]; alu_co = sum_a[4]; alu_wa = 1'b1; end
      OP_MOV_AB: begin alu_data = alu_b;  alu_wa = 1'b1; end
      OP_IN_A:   begin alu_data = alu_in; alu_wa = 1'b1; end
      OP_MOV_A:  begin alu_wa = 1'b1; end
      OP_MOV_BA: begin alu_data = alu_a;  alu_wb = 1'b1; end
      OP_ADD_B:  begin alu_data = sum_b[3:0]; alu_co = sum_b[4]; alu_wb = 1'b1; end
      OP_IN_B:   begin alu_data = alu_in; alu_wb = 1'b1; end
      OP_MOV_B:  begin alu_wb = 1'b1; end
      OP_OUT_B:  begin alu_data = alu_b;  alu_wo = 1'b1; end
      OP_OUT_I:  begin alu_wo = 1'b1; end
      OP_JNC:    begin alu_jump = ~alu_ci; end
      OP_JMP:    begin alu_jump = 1'b1; end
      default:   begin end
    endcase
  end

  // Instruction-level reference model of the architectural state.
  int m_a, m_b, m_o, m_c, m_pc;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_o = 0; m_c = 0; m_pc = 0;
  endtask

  task automatic model_exec(input int ins, input int inp);
    int op, im, next_pc;
    op = ins / 16;
    im = ins % 16;
    next_pc = (m_pc + 1) % 16;
    case (op)
      0:  begin m_c = (m_a + im) / 16; m_a = (m_a + im) % 16; end
      1:  begin m_a = m_b; m_c = 0; end
      2:  begin m_a = inp; m_c = 0; end
      3:  begin m_a = im;  m_c = 0; end
      4:  begin m_b = m_a; m_c = 0; end
      5:  begin m_c = (m_b + im) / 16; m_b = (m_b + im) % 16; end
      6:  begin m_b = inp; m_c = 0; end
      7:  begin m_b = im;  m_c = 0; end
      9:  begin m_o = m_b; m_c = 0; end
      11: begin m_o = im;  m_c = 0; end
      14: begin if (m_c == 0) next_pc = im; m_c = 0; end
      15: begin next_pc = im; m_c = 0; end
      default: m_c = 0;
    endcase
    m_pc = next_pc;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  // Waits (bounded) for the instr_done pulse; returns cycles waited.
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (instr_done) break;
    end
    if (instr_done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: instr_done=%b after %0d cycles, required 1", name, instr_done, cyc);
    end
  endtask

  task automatic step_one(input string name);
    int cyc;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_done(name, cyc);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] instr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic       c;
    logic [3:0] pc;
  } vec_t;

  vec_t vecs [13];

  initial begin : main
    int cyc, cyc2, cur_in;

    vecs[0]  = '{4'h0, 8'h35, 4'h5, 4'h0, 4'h0, 1'b0, 4'h1};
    vecs[1]  = '{4'h1, 8'h0F, 4'h4, 4'h0, 4'h0, 1'b1, 4'h2};
    vecs[2]  = '{4'h2, 8'h40, 4'h4, 4'h4, 4'h0, 1'b0, 4'h3};
    vecs[3]  = '{4'h3, 8'h5D, 4'h4, 4'h1, 4'h0, 1'b1, 4'h4};
    vecs[4]  = '{4'h4, 8'hE7, 4'h4, 4'h1, 4'h0, 1'b0, 4'h5};
    vecs[5]  = '{4'h5, 8'h90, 4'h4, 4'h1, 4'h1, 1'b0, 4'h6};
    vecs[6]  = '{4'h6, 8'h20, 4'hA, 4'h1, 4'h1, 1'b0, 4'h7};
    vecs[7]  = '{4'h7, 8'hE9, 4'hA, 4'h1, 4'h1, 1'b0, 4'h9};
    vecs[8]  = '{4'h9, 8'hBC, 4'hA, 4'h1, 4'hC, 1'b0, 4'hA};
    vecs[9]  = '{4'hA, 8'h0F, 4'h9, 4'h1, 4'hC, 1'b1, 4'hB};
    vecs[10] = '{4'hB, 8'h79, 4'h9, 4'h9, 4'hC, 1'b0, 4'hC};
    vecs[11] = '{4'hC, 8'hFF, 4'h9, 4'h9, 4'hC, 1'b0, 4'hF};
    vecs[12] = '{4'hF, 8'h99, 4'h9, 4'h9, 4'h9, 1'b0, 4'h0};

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // ---- Reset state ----
    do_reset();
    check("reset pc",         int'(pc), 0);
    check("reset A",          int'(alu_a), 0);
    check("reset B",          int'(alu_b), 0);
    check("reset OUT",        int'(out_port), 0);
    check("reset C",          int'(alu_ci), 0);
    check("reset IR",         int'({alu_cmd, alu_imd}), 0);
    check("reset busy",       int'(busy), 0);
    check("reset rom_en",     int'(rom_en), 0);
    check("reset instr_done", int'(instr_done), 0);
    check("reset alu_in",     int'(alu_in), 0);

    // ---- Single step, cycle by cycle ----
    rom[0] = 8'h35;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step fetch rom_en",   int'(rom_en), 1);
    check("step fetch rom_addr", int'(rom_addr), 0);
    check("step fetch busy",     int'(busy), 1);
    @(negedge clk);
    check("step latch rom_en",   int'(rom_en), 0);
    check("step latch busy",     int'(busy), 1);
    @(negedge clk);
    check("step exec alu_cmd",   int'(alu_cmd), 3);
    check("step exec alu_imd",   int'(alu_imd), 5);
    check("step exec busy",      int'(busy), 1);
    @(negedge clk);
    check("step done pulse",     int'(instr_done), 1);
    check("step done A",         int'(alu_a), 5);
    check("step done pc",        int'(pc), 1);
    check("step done busy",      int'(busy), 0);
    check("step ir held cmd",    int'(alu_cmd), 3);
    @(negedge clk);
    check("step done one cycle", int'(instr_done), 0);
    check("step stays idle",     int'(busy), 0);

    // ---- Table-driven single-step program ----
    do_reset();
    in_port = 4'hA;
    for (int i = 0; i < 13; i++) rom[vecs[i].addr] = vecs[i].instr;
    for (int i = 0; i < 13; i++) begin
      step_one("vec step");
      check($sformatf("vec%0d A", i),   int'(alu_a),    int'(vecs[i].a));
      check($sformatf("vec%0d B", i),   int'(alu_b),    int'(vecs[i].b));
      check($sformatf("vec%0d OUT", i), int'(out_port), int'(vecs[i].o));
      check($sformatf("vec%0d C", i),   int'(alu_ci),   int'(vecs[i].c));
      check($sformatf("vec%0d pc", i),  int'(pc),       int'(vecs[i].pc));
    end

    // ---- Run mode: add with carry, throughput, run dropped in LATCH ----
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h0F;
    rom[1] = 8'h01;
    run = 1'b1;
    wait_done("run i0", cyc);
    check("run i0 latency", cyc, 4);
    check("run i0 A", int'(alu_a), 15);
    check("run i0 C", int'(alu_ci), 0);
    check("run i0 busy", int'(busy), 1);
    wait_done("run i1", cyc2);
    check("run throughput", cyc2, 3);
    check("run i1 A", int'(alu_a), 0);
    check("run i1 C", int'(alu_ci), 1);
    @(negedge clk);
    check("run latch state busy", int'(busy), 1);
    check("run latch rom_en", int'(rom_en), 0);
    run = 1'b0;
    wait_done("run drop", cyc);
    check("run drop cycles", cyc, 2);
    check("run drop busy", int'(busy), 0);
    check("run drop pc", int'(pc), 3);
    check("run drop C", int'(alu_ci), 0);
    repeat (3) @(negedge clk);
    check("run drop stays idle", int'(busy), 0);
    check("run drop pc held", int'(pc), 3);

    // ---- Conditional jump on carry set / clear ----
    do_reset();
    rom[0] = 8'h0F;
    rom[1] = 8'h01;
    rom[2] = 8'hE7;
    rom[3] = 8'h30;
    rom[4] = 8'hE7;
    step_one("jnc s0");
    step_one("jnc s1");
    check("jnc carry before", int'(alu_ci), 1);
    step_one("jnc s2");
    check("jnc no jump pc", int'(pc), 3);
    step_one("jnc s3");
    check("jnc clear C", int'(alu_ci), 0);
    step_one("jnc s4");
    check("jnc jump pc", int'(pc), 7);

    // ---- Reset during EXEC aborts the commit ----
    do_reset();
    rom[0] = 8'h37;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    check("abort exec cmd", int'(alu_cmd), 3);
    check("abort exec imd", int'(alu_imd), 7);
    nrst = 1'b0;
    @(negedge clk);
    check("abort A", int'(alu_a), 0);
    check("abort pc", int'(pc), 0);
    check("abort busy", int'(busy), 0);
    check("abort instr_done", int'(instr_done), 0);
    check("abort IR", int'({alu_cmd, alu_imd}), 0);
    nrst = 1'b1;
    rom[0] = 8'h35;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("abort refetch rom_addr", int'(rom_addr), 0);
    check("abort refetch rom_en", int'(rom_en), 1);
    wait_done("abort refetch", cyc);
    check("abort refetch A", int'(alu_a), 5);

    // ---- Randomized free-running program vs. instruction model ----
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
    model_reset();
    in_port = 4'($urandom_range(0, 15));
    run = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cur_in = int'(in_port);
      model_exec(int'(rom[m_pc]), cur_in);
      wait_done("rand", cyc);
      if (i > 0) check("rand throughput", cyc, 3);
      check("rand A",   int'(alu_a),    m_a);
      check("rand B",   int'(alu_b),    m_b);
      check("rand OUT", int'(out_port), m_o);
      check("rand C",   int'(alu_ci),   m_c);
      check("rand pc",  int'(pc),       m_pc);
      in_port = 4'($urandom_range(0, 15));
      // Outside IDLE, step must have no effect.
      step = 1'($urandom_range(0, 1));
      if (i == 59) begin
        run  = 1'b0;
        step = 1'b0;
      end
    end
    cur_in = int'(in_port);
    model_exec(int'(rom[m_pc]), cur_in);
    wait_done("rand last", cyc);
    check("rand last A",    int'(alu_a), m_a);
    check("rand last pc",   int'(pc), m_pc);
    check("rand last busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
